// File: rtl/curve_lut_pkg.sv
// Shared constants and FSM state type for the curve LUT slice.
// Imported by curve_lut_dpram and curve_lut_ram.
package curve_lut_pkg;

  localparam int LUT_DEPTH = 256;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_e;

endpackage

// File: rtl/curve_lut_dpram.sv
// Simple dual-port 512x8 RAM: one write port, one registered read port.
// Ports: clk, we_i/waddr_i/wdata_i write side, raddr_i/rdata_o read side.
module curve_lut_dpram
  import curve_lut_pkg::*;
#(
  parameter int AW = ADDR_W + 1,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/curve_lut_ram.sv
// Ping-pong programmable curve LUT: byte-stream load, swap on vsync rise.
// Ports: cfg_* load handshake, swap_done/active_bank status, per_*/post_*
// video in/out (1-cycle latency). Optional CURVE_LUT_BYPASS_EN adds bypass.
module curve_lut_ram
  import curve_lut_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              swap_done,
  output logic              active_bank,
`ifdef CURVE_LUT_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_data,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              bank_q, bank_d;
  logic              valid_q, valid_d;
  logic              swap_q, swap;
  logic              we;
  logic              vs_q, hr_q, ck_q;
  logic [DATA_W-1:0] pix_q;
  logic              use_q, use_d;
  logic [DATA_W-1:0] rd_data;
  logic              rise;

  assign rise = per_frame_vsync & ~vs_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bank_d  = bank_q;
    valid_d = valid_q;
    swap    = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          idx_d = '0;
        end else if (cfg_valid) begin
          we    = 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == ADDR_W'(LUT_DEPTH - 1)) state_d = PEND;
        end
      end
      PEND: begin
        if (rise) begin
          swap    = 1'b1;
          bank_d  = ~bank_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        // A restart landing on the swap edge loads the freshly freed bank.
        if (cfg_start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CURVE_LUT_BYPASS_EN
  assign use_d = valid_q & ~bypass;
`else
  assign use_d = valid_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bank_q  <= 1'b0;
      valid_q <= 1'b0;
      swap_q  <= 1'b0;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      ck_q    <= 1'b0;
      pix_q   <= '0;
      use_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bank_q  <= bank_d;
      valid_q <= valid_d;
      swap_q  <= swap;
      vs_q    <= per_frame_vsync;
      hr_q    <= per_frame_href;
      ck_q    <= per_frame_clken;
      pix_q   <= per_img_data;
      // Select is sampled with the pixel so the swap-cycle pixel keeps
      // the old mapping (identity before the first curve).
      use_q   <= use_d;
    end
  end

  curve_lut_dpram u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i ({~bank_q, idx_q}),
    .wdata_i (cfg_data),
    .raddr_i ({bank_q, per_img_data}),
    .rdata_o (rd_data)
  );

  assign cfg_ready        = (state_q == LOAD);
  assign swap_done        = swap_q;
  assign active_bank      = bank_q;
  assign post_frame_vsync = vs_q;
  assign post_frame_href  = hr_q;
  assign post_frame_clken = ck_q;
  assign post_img_data    = use_q ? rd_data : pix_q;

endmodule
